// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - pcsrc encodings used by decode to select the next PC
//   - fetch FSM state enum
//   - NOP word used for IF/ID bubbles
//   - default reset PC
//   - select_target(): picks the redirect target for a given pcsrc
package fetch_pkg;

   localparam logic [1:0] PCSRC_PC4 = 2'b00;
   localparam logic [1:0] PCSRC_B   = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;
   localparam logic [1:0] PCSRC_JR  = 2'b11;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      START = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } fetch_state_e;

   // Redirect target selected by decode. PCSRC_PC4 never reaches the
   // redirect path (it is not a redirect), so it maps to the branch target
   // only to keep the function total.
   function automatic logic [31:0] select_target(
      input logic [1:0]  pcsrc,
      input logic [31:0] npcb,
      input logic [31:0] npcj,
      input logic [31:0] npcjr
   );
      logic [31:0] t;
      case (pcsrc)
         PCSRC_J:  t = npcj;
         PCSRC_JR: t = npcjr;
         default:  t = npcb;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: request/acknowledge bus between the fetch stage and the
// instruction memory.
//   req   : fetch request (master -> slave)
//   addr  : fetch address (master -> slave)
//   ack   : transfer complete when req & ack (slave -> master)
//   rdata : instruction word, valid in the ack cycle (slave -> master)
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register (instruction, pc+4, valid).
//   clk      : clock
//   reset    : asynchronous active-low reset (clears to a bubble)
//   load     : capture instr_in/pc4_in with valid = 1
//   bubble   : insert a nop bubble (instr = NOP, pc4 = 0, valid = 0)
//   instr_in, pc4_in : data to capture on load
//   instr, pc4, valid : register outputs to decode
// With neither load nor bubble the register holds; load has priority.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr <= NOP;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end else if (bubble) begin
         instr <= NOP;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC, fetches over a req/ack bus from a variable-latency memory,
// drives IF/ID, honours decode redirects with a branch delay slot, and
// buffers one completed fetch while decode is stalled.
//   clk, reset        : clock, asynchronous active-low reset
//   stall_D           : decode stalled; IF/ID holds, redirects ignored
//   pcsrc_D           : next-PC select from decode (pc4/branch/jump/jr)
//   npcb, npcj, npcjr : redirect targets
//   imem              : instruction memory bus (master side)
//   instr_D, pc4_D, valid_D : IF/ID register outputs
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall_D,
   input  logic [1:0]          pcsrc_D,
   input  logic [31:0]         npcb,
   input  logic [31:0]         npcj,
   input  logic [31:0]         npcjr,
   fetch_unit_if.master        imem,
   output logic [31:0]         instr_D,
   output logic [31:0]         pc4_D,
   output logic                valid_D
);

   fetch_state_e state_reg;
   logic         req_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  pend_pc_reg;
   logic         pend_v_reg;
   logic [31:0]  buf_instr_reg;
   logic [31:0]  buf_pc4_reg;

   logic [31:0]  pc_plus4;
   logic [31:0]  target;
   logic         redirect;
   logic         ack_fire;
   logic [31:0]  next_pc;

   logic         ifid_load;
   logic         ifid_bubble;
   logic [31:0]  ifid_instr_in;
   logic [31:0]  ifid_pc4_in;

   // Bus outputs come straight from registers: no path from ack to req/addr.
   assign imem.req  = req_reg;
   assign imem.addr = pc_reg;

   assign pc_plus4 = pc_reg + 32'd4;
   assign target   = select_target(pcsrc_D, npcb, npcj, npcjr);
   // Only a real, unstalled instruction in decode may redirect.
   assign redirect = valid_D && !stall_D && (pcsrc_D != PCSRC_PC4);
   assign ack_fire = (state_reg == FETCH) && imem.ack;
   // A redirect arriving with the ack wins over an older pending one.
   assign next_pc  = redirect   ? target :
                     pend_v_reg ? pend_pc_reg : pc_plus4;

   // IF/ID control
   always_comb begin
      ifid_load     = 1'b0;
      ifid_bubble   = 1'b0;
      ifid_instr_in = imem.rdata;
      ifid_pc4_in   = pc_plus4;
      case (state_reg)
         START: begin
            ifid_bubble = !stall_D;
         end
         FETCH: begin
            if (!stall_D) begin
               if (imem.ack) ifid_load   = 1'b1;
               else          ifid_bubble = 1'b1;
            end
         end
         FULL: begin
            ifid_instr_in = buf_instr_reg;
            ifid_pc4_in   = buf_pc4_reg;
            ifid_load     = !stall_D;
         end
         default: begin
            ifid_bubble = !stall_D;
         end
      endcase
   end

   // FSM, PC, pending redirect and skid buffer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= START;
         req_reg       <= 1'b0;
         pc_reg        <= RESET_PC;
         pend_pc_reg   <= 32'h0;
         pend_v_reg    <= 1'b0;
         buf_instr_reg <= 32'h0;
         buf_pc4_reg   <= 32'h0;
      end else begin
         case (state_reg)
            START: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
            end
            FETCH: begin
               if (ack_fire) begin
                  pc_reg     <= next_pc;
                  pend_v_reg <= 1'b0;
                  if (stall_D) begin
                     // Decode cannot take the word: park it and stop fetching.
                     buf_instr_reg <= imem.rdata;
                     buf_pc4_reg   <= pc_plus4;
                     state_reg     <= FULL;
                     req_reg       <= 1'b0;
                  end
               end else if (redirect) begin
                  // The in-flight fetch is the delay slot; redirect after it.
                  pend_pc_reg <= target;
                  pend_v_reg  <= 1'b1;
               end
            end
            FULL: begin
               if (!stall_D) begin
                  // The buffered word is the delay slot, so a redirect here
                  // replaces the PC directly.
                  if (redirect) pc_reg <= target;
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
               end
            end
            default: begin
               state_reg <= START;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load     (ifid_load),
      .bubble   (ifid_bubble),
      .instr_in (ifid_instr_in),
      .pc4_in   (ifid_pc4_in),
      .instr    (instr_D),
      .pc4      (pc4_D),
      .valid    (valid_D)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit.
// Each table row gives the decode/memory inputs for one cycle, the bus
// outputs expected before the edge, and the IF/ID contents expected after it.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall_D;
   logic [1:0]  pcsrc_D;
   logic [31:0] npcb;
   logic [31:0] npcj;
   logic [31:0] npcjr;
   logic [31:0] instr_D;
   logic [31:0] pc4_D;
   logic        valid_D;

   int tests_run;
   int tests_failed;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk     (clk),
      .reset   (reset),
      .stall_D (stall_D),
      .pcsrc_D (pcsrc_D),
      .npcb    (npcb),
      .npcj    (npcj),
      .npcjr   (npcjr),
      .imem    (imem.master),
      .instr_D (instr_D),
      .pc4_D   (pc4_D),
      .valid_D (valid_D)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a distinct word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'hC0DE} ^ 32'h2400_0000;
   endfunction

   assign imem.rdata = mem_word(imem.addr);

   typedef struct {
      logic        stall;
      logic [1:0]  pcsrc;
      logic        ack;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
      logic        exp_valid;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic st, input logic [1:0] ps, input logic ak,
                               input logic rq, input logic [31:0] ad,
                               input logic [31:0] ins, input logic [31:0] p4,
                               input logic vl);
      vec_t v;
      v.stall = st; v.pcsrc = ps; v.ack = ak; v.exp_req = rq; v.exp_addr = ad;
      v.exp_instr = ins; v.exp_pc4 = p4; v.exp_valid = vl;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset   = 1'b0;
      stall_D = 1'b0;
      pcsrc_D = 2'b00;
      npcb    = 32'h0000_3040;
      npcj    = 32'h0000_3080;
      npcjr   = 32'h0000_3100;
      imem.ack = 1'b0;

      //            stall pcsrc ack  req addr          instr                   pc4           valid
      vecs[0]  = mk(0, 2'b00, 1, 0, 32'h3000, 32'h0,                32'h0,    0); // START
      vecs[1]  = mk(0, 2'b00, 1, 1, 32'h3000, mem_word(32'h3000),   32'h3004, 1);
      vecs[2]  = mk(0, 2'b00, 1, 1, 32'h3004, mem_word(32'h3004),   32'h3008, 1);
      vecs[3]  = mk(0, 2'b01, 0, 1, 32'h3008, 32'h0,                32'h0,    0); // branch, fetch waits
      vecs[4]  = mk(0, 2'b00, 0, 1, 32'h3008, 32'h0,                32'h0,    0);
      vecs[5]  = mk(0, 2'b00, 1, 1, 32'h3008, mem_word(32'h3008),   32'h300C, 1); // delay slot
      vecs[6]  = mk(0, 2'b00, 1, 1, 32'h3040, mem_word(32'h3040),   32'h3044, 1); // branch target
      vecs[7]  = mk(1, 2'b00, 1, 1, 32'h3044, mem_word(32'h3040),   32'h3044, 1); // ack under stall
      vecs[8]  = mk(1, 2'b00, 0, 0, 32'h3048, mem_word(32'h3040),   32'h3044, 1); // FULL hold
      vecs[9]  = mk(0, 2'b00, 0, 0, 32'h3048, mem_word(32'h3044),   32'h3048, 1); // drain buffer
      vecs[10] = mk(1, 2'b00, 1, 1, 32'h3048, mem_word(32'h3044),   32'h3048, 1); // ack under stall
      vecs[11] = mk(0, 2'b11, 0, 0, 32'h304C, mem_word(32'h3048),   32'h304C, 1); // jr in FULL
      vecs[12] = mk(0, 2'b00, 1, 1, 32'h3100, mem_word(32'h3100),   32'h3104, 1);
      vecs[13] = mk(0, 2'b10, 1, 1, 32'h3104, mem_word(32'h3104),   32'h3108, 1); // j with ack
      vecs[14] = mk(0, 2'b00, 1, 1, 32'h3080, mem_word(32'h3080),   32'h3084, 1);
      vecs[15] = mk(1, 2'b01, 0, 1, 32'h3084, mem_word(32'h3080),   32'h3084, 1); // branch ignored
      vecs[16] = mk(0, 2'b00, 0, 1, 32'h3084, 32'h0,                32'h0,    0);
      vecs[17] = mk(0, 2'b00, 1, 1, 32'h3084, mem_word(32'h3084),   32'h3088, 1);
      vecs[18] = mk(0, 2'b00, 1, 1, 32'h3088, mem_word(32'h3088),   32'h308C, 1);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req",   {31'h0, imem.req}, 32'h0);
      check("rst_addr",  imem.addr,         32'h3000);
      check("rst_instr", instr_D,           32'h0);
      check("rst_pc4",   pc4_D,             32'h0);
      check("rst_valid", {31'h0, valid_D},  32'h0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         stall_D  = vecs[i].stall;
         pcsrc_D  = vecs[i].pcsrc;
         imem.ack = vecs[i].ack;
         #1;
         check($sformatf("v%0d_req", i),   {31'h0, imem.req}, {31'h0, vecs[i].exp_req});
         check($sformatf("v%0d_addr", i),  imem.addr,         vecs[i].exp_addr);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_instr", i), instr_D,           vecs[i].exp_instr);
         check($sformatf("v%0d_pc4", i),   pc4_D,             vecs[i].exp_pc4);
         check($sformatf("v%0d_valid", i), {31'h0, valid_D},  {31'h0, vecs[i].exp_valid});
         $display("[TB] vec %0d addr=%08h req=%0b instr=%08h pc4=%08h valid=%0b",
                  i, vecs[i].exp_addr, vecs[i].exp_req, instr_D, pc4_D, valid_D);
         @(negedge clk);
      end

      // Reset asserted mid-fetch (at 0x308C, ack withheld): asynchronous clear
      stall_D  = 1'b0;
      pcsrc_D  = 2'b00;
      imem.ack = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("arst_req",   {31'h0, imem.req}, 32'h0);
      check("arst_valid", {31'h0, valid_D},  32'h0);
      check("arst_instr", instr_D,           32'h0);
      check("arst_addr",  imem.addr,         32'h3000);
      $display("[TB] async reset mid-fetch req=%0b valid=%0b addr=%08h", imem.req, valid_D, imem.addr);
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      imem.ack = 1'b1;
      @(posedge clk);
      #1;
      check("rel_req",  {31'h0, imem.req}, 32'h1);
      check("rel_addr", imem.addr,         32'h3000);
      @(posedge clk);
      #1;
      check("rel_instr", instr_D,          mem_word(32'h3000));
      check("rel_pc4",   pc4_D,            32'h3004);
      check("rel_valid", {31'h0, valid_D}, 32'h1);
      $display("[TB] restart instr=%08h pc4=%08h valid=%0b", instr_D, pc4_D, valid_D);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, issues requests to a variable-latency instruction memory over a req/ack handshake, and drives the IF/ID pipeline register that decode consumes (`instr`, `pc4`). It also accepts decode's next-PC selection (`pcsrc_D` plus the branch, jump and jr targets), honouring the MIPS branch delay slot. When decode is stalled, it buffers one completed fetch.

## Interface
- `RESET_PC`, default 32'h0000_3000: first fetch address after reset.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `stall_D`  in  1: hazard unit holds IF/ID and blocks redirect acceptance.
- `pcsrc_D`  in  2: 00 = pc+4, 01 = branch taken, 10 = j/jal, 11 = jr.
- `npcb`, `npcj`, `npcjr`  in  32 each: redirect targets from decode.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, always equal to the PC register.
- `imem_ack`  in  1: transfer completes in any cycle where `imem_req` & `imem_ack`.
- `imem_rdata`  in  32: instruction word, valid in the ack cycle.
- `instr_D`  out  32: IF/ID instruction.
- `pc4_D`  out  32: IF/ID fetch address + 4.
- `valid_D`  out  1: IF/ID holds a real instruction. 0 means `instr_D` = 32'h0 (nop bubble).

## Operation
- States:
  - START: reset state; `imem_req` = 0.
  - FETCH: `imem_req` = 1.
  - FULL: a completed fetch is buffered; `imem_req` = 0.
- Transitions:
  - START → FETCH unconditionally on the first edge after reset deasserts.
  - FETCH with ack and `stall_D` = 0: IF/ID ← {`imem_rdata`, pc+4, 1}; PC ← next; stay in FETCH.
  - FETCH with ack and `stall_D` = 1: buffer ← {`imem_rdata`, pc+4}; PC ← next; go to FULL.
  - FETCH without ack: `imem_addr` held stable; IF/ID ← bubble unless stalled.
  - FULL with `stall_D` = 0: IF/ID ← buffer with valid 1; go to FETCH.
  - FULL with `stall_D` = 1: hold.
- Redirect is accepted in a cycle where `valid_D` & !`stall_D` & `pcsrc_D` != 0. The target is chosen by `pcsrc_D`.
  - In FETCH with ack the same cycle: next = target.
  - In FETCH without ack: latch the target in `pend_pc`/`pend_v`. This in-flight fetch is the delay slot.
  - In FULL: PC ← target directly. The buffered word is the delay slot.
- next = target if a redirect is accepted this cycle, else `pend_pc` if `pend_v`, else pc+4. `pend_v` clears when a fetch completes.
- A second redirect while `pend_v` is set overwrites it (last wins). This corresponds to a branch in a delay slot, which is architecturally undefined.
- Redirect input is ignored when `valid_D` = 0 or `stall_D` = 1. Decode re-presents it after the stall.
- No flush: the delay-slot instruction always reaches decode.
- While `stall_D` = 1, IF/ID holds its value, including a bubble.
- Arithmetic: 32-bit, wraps modulo 2^32. Word alignment is not checked; bits [1:0] pass through.

## Timing
- Reset values: PC = `RESET_PC`, state = START, `imem_req` = 0, `instr_D` = 0, `pc4_D` = 0, `valid_D` = 0, `pend_v` = 0, buffer = 0.
- Reset asserted mid-transfer: `imem_req` drops immediately (asynchronous). An outstanding memory response must be discarded by the memory.
- First request is asserted in the cycle after the first rising edge following reset release.
- Latency: instruction appears on `instr_D` the edge after its ack (zero-wait ack gives one instruction per cycle).
- FULL → FETCH costs one request-free cycle.
- `imem_req`/`imem_addr` are registered-state decoded. There is no combinational path from `imem_ack` to them.

## Structure
- Shared package `fetch_pkg`:
  - `pcsrc` encodings `PCSRC_PC4`/`B`/`J`/`JR`.
  - state enum START/FETCH/FULL.
  - `NOP` = 32'h0.
  - default `RESET_PC`.
- Sub-module `if_id_reg`: instr/pc4/valid register with load, hold and bubble controls and asynchronous active-low reset.
- The FSM, PC, pending redirect and skid buffer live in `fetch_unit`.

## Test plan
- Reset release, ack tied high: addresses 0x3000, 0x3004, 0x3008 on consecutive cycles. `pc4_D` = 0x3004, 0x3008… with `valid_D` = 1 from the edge after the first ack.
- Ack latency 3: `imem_addr` stays 0x3000 for 3 cycles with `imem_req` = 1. `valid_D` = 0 bubbles, then `instr_D` = rdata and `pc4_D` = 0x3004.
- Stall asserted across the ack of 0x3004: state FULL, `imem_req` = 0, IF/ID unchanged. Stall release: `instr_D` = buffered word, then the request for 0x3008 follows.
- Branch in D (`pc4_D` = 0x3008, `pcsrc_D` = 01, `npcb` = 0x3040) while fetch of 0x3008 waits 2 cycles: the 0x3008 word reaches decode, next `imem_addr` = 0x3040.
- jr in D while in FULL (`npcjr` = 0x3100): buffered delay slot delivered, next request address = 0x3100. No fetch of pc+4.
- Reset asserted mid-fetch at 0x3010: `imem_req` and `valid_D` go to 0 immediately. After release, fetch restarts at 0x3000.
